spi_xip_ctrl: RTL and testbench

SPI_XIP_CTRL -- requirements
Module: spi_xip_ctrl

---
 rtl/spi_xip_pkg.sv | 37 +++
 rtl/spi_reg_bus_master.sv | 56 +++++
 rtl/spi_xip_ctrl.sv | 153 +++++++++++++++
 tb/tb_spi_xip_ctrl.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/spi_xip_pkg.sv
// Shared types and constants for the SPI execute-in-place bridge.
// Holds the sequencer states, SPI core register map, CTRL words and the flash read opcode.
package spi_xip_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_DIV,
    ST_TX1,
    ST_TX0,
    ST_SS,
    ST_CTRL,
    ST_GO,
    ST_POLL,
    ST_RX,
    ST_SSCLR,
    ST_RESP
  } state_t;

  localparam logic [4:0] REG_RX0  = 5'h00;
  localparam logic [4:0] REG_TX0  = 5'h00;
  localparam logic [4:0] REG_TX1  = 5'h04;
  localparam logic [4:0] REG_CTRL = 5'h10;
  localparam logic [4:0] REG_DIV  = 5'h14;
  localparam logic [4:0] REG_SS   = 5'h18;

  // CHAR_LEN=64 with Tx_NEG; the START variant additionally sets GO_BSY.
  localparam logic [31:0] CTRL_CFG    = 32'h0000_0440;
  localparam logic [31:0] CTRL_START  = 32'h0000_0540;
  localparam int          CTRL_GO_BIT = 8;

  localparam logic [7:0] FLASH_READ = 8'h03;

  function automatic logic [31:0] byte_swap(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

endpackage

// File: rtl/spi_reg_bus_master.sv
// Single-access strobe/ack master for the SPI core register bus.
// Strobe is held until ack, then dropped with a one-cycle done pulse carrying the read data.
module spi_reg_bus_master (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic        wr,
  input  logic [4:0]  adr,
  input  logic [31:0] wdat,
  output logic        done,
  output logic [31:0] rdat,
  output logic [4:0]  spi_adr,
  output logic [31:0] spi_dat_o,
  input  logic [31:0] spi_dat_i,
  output logic [3:0]  spi_sel,
  output logic        spi_we,
  output logic        spi_stb,
  output logic        spi_cyc,
  input  logic        spi_ack
);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      done      <= 1'b0;
      rdat      <= '0;
      spi_adr   <= '0;
      spi_dat_o <= '0;
      spi_sel   <= '0;
      spi_we    <= 1'b0;
      spi_stb   <= 1'b0;
      spi_cyc   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (spi_stb) begin
        if (spi_ack) begin
          spi_stb   <= 1'b0;
          spi_cyc   <= 1'b0;
          spi_we    <= 1'b0;
          spi_sel   <= '0;
          spi_adr   <= '0;
          spi_dat_o <= '0;
          rdat      <= spi_dat_i;
          done      <= 1'b1;
        end
      end else if (start) begin
        spi_stb   <= 1'b1;
        spi_cyc   <= 1'b1;
        spi_sel   <= 4'hF;
        spi_we    <= wr;
        spi_adr   <= adr;
        spi_dat_o <= wdat;
      end
    end
  end

endmodule

// File: rtl/spi_xip_ctrl.sv
// APB-to-SPI-flash XIP bridge: each in-window read drives the SPI core through a full 0x03 read.
// XIP_WRITE_ERR_EN: when defined, in-range writes get pslverr=1 instead of a silent OK.
module spi_xip_ctrl
  import spi_xip_pkg::*;
#(
  parameter logic [31:0] FLASH_BASE = 32'h3000_0000,
  parameter logic [15:0] SCK_DIV    = 16'h0001,
  parameter logic [7:0]  SS_MASK    = 8'h01
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        in_psel,
  input  logic        in_penable,
  input  logic        in_pwrite,
  input  logic [31:0] in_paddr,
  input  logic [31:0] in_pwdata,
  input  logic [3:0]  in_pstrb,
  output logic        in_pready,
  output logic        in_pslverr,
  output logic [31:0] in_prdata,
  output logic [4:0]  spi_adr,
  output logic [31:0] spi_dat_o,
  input  logic [31:0] spi_dat_i,
  output logic [3:0]  spi_sel,
  output logic        spi_we,
  output logic        spi_stb,
  output logic        spi_cyc,
  input  logic        spi_ack
);

`ifdef XIP_WRITE_ERR_EN
  localparam logic WR_ERR = 1'b1;
`else
  localparam logic WR_ERR = 1'b0;
`endif

  localparam logic [31:0] FLASH_TOP = FLASH_BASE + 32'h00FF_FFFF;

  state_t      state;
  logic [21:0] word_addr;
  logic [31:0] rx_data;
  logic        launched;
  logic        start;
  logic        done;
  logic [31:0] rdat;
  logic        acc_we;
  logic [4:0]  acc_adr;
  logic [31:0] acc_dat;
  logic        in_range;
  logic        unused_ok;

  assign unused_ok = ^{in_pwdata, in_pstrb};
  assign in_range  = (in_paddr >= FLASH_BASE) && (in_paddr <= FLASH_TOP);
  assign start     = (state != ST_IDLE) && (state != ST_RESP) && !launched;

  always_comb begin
    acc_we  = 1'b1;
    acc_adr = REG_TX0;
    acc_dat = '0;
    case (state)
      ST_DIV:   begin acc_adr = REG_DIV;  acc_dat = {16'h0, SCK_DIV}; end
      ST_TX1:   begin acc_adr = REG_TX1;  acc_dat = {FLASH_READ, word_addr, 2'b00}; end
      ST_TX0:   begin acc_adr = REG_TX0;  acc_dat = '0; end
      ST_SS:    begin acc_adr = REG_SS;   acc_dat = {24'h0, SS_MASK}; end
      ST_CTRL:  begin acc_adr = REG_CTRL; acc_dat = CTRL_CFG; end
      ST_GO:    begin acc_adr = REG_CTRL; acc_dat = CTRL_START; end
      ST_POLL:  begin acc_we = 1'b0; acc_adr = REG_CTRL; end
      ST_RX:    begin acc_we = 1'b0; acc_adr = REG_RX0; end
      ST_SSCLR: begin acc_adr = REG_SS;   acc_dat = '0; end
      default:  ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      word_addr  <= '0;
      rx_data    <= '0;
      launched   <= 1'b0;
      in_pready  <= 1'b0;
      in_pslverr <= 1'b0;
      in_prdata  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_psel && in_penable) begin
            word_addr <= in_paddr[23:2];
            if (in_pwrite || !in_range) begin
              state      <= ST_RESP;
              in_pready  <= 1'b1;
              in_pslverr <= in_pwrite ? WR_ERR : 1'b1;
            end else begin
              state <= ST_DIV;
            end
          end
        end
        ST_RESP: begin
          state      <= ST_IDLE;
          in_pready  <= 1'b0;
          in_pslverr <= 1'b0;
          in_prdata  <= '0;
        end
        default: begin
          if (start) launched <= 1'b1;
          // Each state advances only once its own access has been acknowledged.
          if (done) begin
            launched <= 1'b0;
            case (state)
              ST_DIV:  state <= ST_TX1;
              ST_TX1:  state <= ST_TX0;
              ST_TX0:  state <= ST_SS;
              ST_SS:   state <= ST_CTRL;
              ST_CTRL: state <= ST_GO;
              ST_GO:   state <= ST_POLL;
              ST_POLL: if (!rdat[CTRL_GO_BIT]) state <= ST_RX;
              ST_RX: begin
                rx_data <= rdat;
                state   <= ST_SSCLR;
              end
              ST_SSCLR: begin
                state      <= ST_RESP;
                in_pready  <= 1'b1;
                in_pslverr <= 1'b0;
                in_prdata  <= byte_swap(rx_data);
              end
              default: state <= ST_IDLE;
            endcase
          end
        end
      endcase
    end
  end

  spi_reg_bus_master u_bus (
    .clock     (clock),
    .reset_n   (reset_n),
    .start     (start),
    .wr        (acc_we),
    .adr       (acc_adr),
    .wdat      (acc_dat),
    .done      (done),
    .rdat      (rdat),
    .spi_adr   (spi_adr),
    .spi_dat_o (spi_dat_o),
    .spi_dat_i (spi_dat_i),
    .spi_sel   (spi_sel),
    .spi_we    (spi_we),
    .spi_stb   (spi_stb),
    .spi_cyc   (spi_cyc),
    .spi_ack   (spi_ack)
  );

endmodule

// File: tb/tb_spi_xip_ctrl.sv
// Scoreboard bench for spi_xip_ctrl: expected SPI accesses and APB responses are queued at stimulus
// time and retired by an SPI register model and the APB driver.
module tb_spi_xip_ctrl;

  typedef struct packed {logic we; logic [4:0] adr; logic [31:0] dat;} acc_t;
  typedef struct packed {logic err; logic [31:0] dat;} resp_t;

`ifdef XIP_WRITE_ERR_EN
  localparam logic WR_ERR_EXP = 1'b1;
`else
  localparam logic WR_ERR_EXP = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic        in_psel = 1'b0, in_penable = 1'b0, in_pwrite = 1'b0;
  logic [31:0] in_paddr = '0, in_pwdata = '0;
  logic [3:0]  in_pstrb = '0;
  logic        in_pready, in_pslverr;
  logic [31:0] in_prdata;
  logic [4:0]  spi_adr;
  logic [31:0] spi_dat_o;
  logic [31:0] spi_dat_i = '0;
  logic [3:0]  spi_sel;
  logic        spi_we, spi_stb, spi_cyc;
  logic        spi_ack = 1'b0;

  acc_t        exp_acc[$];
  resp_t       exp_resp[$];
  int          n_tests = 0, n_fail = 0;
  int          poll_left = 0, ctrl_reads = 0;
  logic [31:0] rx_val = '0;

  acc_t        m_acc, m_exp;
  logic [31:0] m_resp;
  int          m_lat;

  always #5 clock = ~clock;

  spi_xip_ctrl dut (
    .clock(clock), .reset_n(reset_n),
    .in_psel(in_psel), .in_penable(in_penable), .in_pwrite(in_pwrite),
    .in_paddr(in_paddr), .in_pwdata(in_pwdata), .in_pstrb(in_pstrb),
    .in_pready(in_pready), .in_pslverr(in_pslverr), .in_prdata(in_prdata),
    .spi_adr(spi_adr), .spi_dat_o(spi_dat_o), .spi_dat_i(spi_dat_i),
    .spi_sel(spi_sel), .spi_we(spi_we), .spi_stb(spi_stb), .spi_cyc(spi_cyc),
    .spi_ack(spi_ack)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic push_read(input logic [31:0] addr, input int busy);
    exp_acc.push_back('{1'b1, 5'h14, 32'h0000_0001});
    exp_acc.push_back('{1'b1, 5'h04, {8'h03, addr[23:2], 2'b00}});
    exp_acc.push_back('{1'b1, 5'h00, 32'h0});
    exp_acc.push_back('{1'b1, 5'h18, 32'h0000_0001});
    exp_acc.push_back('{1'b1, 5'h10, 32'h0000_0440});
    exp_acc.push_back('{1'b1, 5'h10, 32'h0000_0540});
    for (int i = 0; i <= busy; i++) exp_acc.push_back('{1'b0, 5'h10, 32'h0});
    exp_acc.push_back('{1'b0, 5'h00, 32'h0});
    exp_acc.push_back('{1'b1, 5'h18, 32'h0});
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, {24'h0, spi_stb, spi_cyc, spi_we, in_pready, spi_sel}, 32'h0);
    check({tag, "_err"}, 32'(in_pslverr), 32'h0);
    check({tag, "_adr"}, 32'(spi_adr), 32'h0);
    check({tag, "_dat"}, spi_dat_o, 32'h0);
    check({tag, "_prdata"}, in_prdata, 32'h0);
  endtask

  // SPI core register model: retires one expected access per strobe, acks after 0-2 cycles.
  initial begin
    forever begin
      @(posedge clock); #1;
      if (reset_n && spi_stb) begin
        m_acc = '{spi_we, spi_adr, spi_dat_o};
        check("acc_sel", 32'(spi_sel), 32'hF);
        check("acc_cyc", 32'(spi_cyc), 32'h1);
        check("acc_expected", 32'(exp_acc.size() != 0), 32'h1);
        if (exp_acc.size() != 0) begin
          m_exp = exp_acc.pop_front();
          check("acc_we_adr", {26'h0, m_acc.we, m_acc.adr}, {26'h0, m_exp.we, m_exp.adr});
          if (m_exp.we) check("acc_wdata", m_acc.dat, m_exp.dat);
        end
        if (m_acc.we) m_resp = 32'hDEAD_BEEF;
        else if (m_acc.adr == 5'h10) begin
          ctrl_reads++;
          m_resp = (poll_left > 0) ? 32'h0000_0540 : 32'h0000_0440;
          if (poll_left > 0) poll_left--;
        end else m_resp = rx_val;
        m_lat = $urandom_range(0, 2);
        for (int k = 0; k < m_lat; k++) begin
          @(posedge clock); #1;
          if (reset_n) begin
            check("acc_hold_ctl", {24'h0, spi_stb, spi_we, 1'b0, spi_adr},
                  {24'h0, 1'b1, m_acc.we, 1'b0, m_acc.adr});
            check("acc_hold_dat", spi_dat_o, m_acc.dat);
          end
        end
        if (reset_n) begin
          spi_ack = 1'b1; spi_dat_i = m_resp;
          @(posedge clock); #1;
          spi_ack = 1'b0; spi_dat_i = '0;
        end
      end
    end
  end

  task automatic do_xfer(input logic [31:0] addr, input logic wr, input int busy, input logic [31:0] rx);
    logic  inr;
    int    cyc;
    resp_t r;
    inr = (addr >= 32'h3000_0000) && (addr <= 32'h30FF_FFFF);
    poll_left = busy; rx_val = rx; ctrl_reads = 0;
    if (wr) exp_resp.push_back('{WR_ERR_EXP, 32'h0});
    else if (!inr) exp_resp.push_back('{1'b1, 32'h0});
    else begin
      push_read(addr, busy);
      exp_resp.push_back('{1'b0, {rx[7:0], rx[15:8], rx[23:16], rx[31:24]}});
    end
    @(posedge clock); #1;
    in_psel = 1'b1; in_penable = 1'b0; in_paddr = addr; in_pwrite = wr;
    in_pwdata = $urandom; in_pstrb = 4'hF;
    @(posedge clock); #1;
    in_penable = 1'b1;
    check("pready_before_accept", 32'(in_pready), 32'h0);
    @(posedge clock);
    cyc = 0;
    do begin @(negedge clock); cyc++; end while (!in_pready && cyc < 3000);
    if (!in_pready) begin
      check("timeout_pready", 32'(in_pready), 32'h1);
      exp_acc.delete(); exp_resp.delete();
    end else begin
      r = exp_resp.pop_front();
      check("prdata", in_prdata, r.dat);
      check("pslverr", 32'(in_pslverr), 32'(r.err));
      if (wr || !inr) check("resp_latency", 32'(cyc), 32'h1);
    end
    @(posedge clock); #1;
    in_psel = 1'b0; in_penable = 1'b0; in_pwrite = 1'b0;
    @(negedge clock);
    check("pready_one_cycle", 32'(in_pready), 32'h0);
    check("prdata_idle", in_prdata, 32'h0);
    check("acc_left", 32'(exp_acc.size()), 32'h0);
    check("ctrl_reads", 32'(ctrl_reads), (wr || !inr) ? 32'h0 : 32'(busy + 1));
  endtask

  initial begin
    int cyc;
    #2 reset_n = 1'b0;
    #10 check_all_zero("reset");
    repeat (2) @(posedge clock);
    #3 reset_n = 1'b1;

    do_xfer(32'h3000_0004, 1'b0, 0, 32'h4433_2211);
    do_xfer(32'h3000_0100, 1'b0, 3, 32'hA5B6_C7D8);
    do_xfer(32'h2000_0000, 1'b0, 0, 32'h0);
    do_xfer(32'h3000_0000, 1'b1, 0, 32'h0);
    do_xfer(32'h3100_0000, 1'b0, 0, 32'h0);
    do_xfer(32'h2FFF_FFFC, 1'b0, 0, 32'h0);
    do_xfer(32'h30FF_FFFC, 1'b1, 0, 32'h0);

    // Reset while the controller is polling CTRL.
    push_read(32'h3000_0010, 50);
    poll_left = 50;
    @(posedge clock); #1;
    in_psel = 1'b1; in_paddr = 32'h3000_0010; in_pwrite = 1'b0;
    @(posedge clock); #1;
    in_penable = 1'b1;
    cyc = 0;
    do begin @(posedge clock); #1; cyc++; end
    while (!(spi_stb && !spi_we && spi_adr == 5'h10) && cyc < 500);
    check("poll_reached", 32'(spi_stb && !spi_we && spi_adr == 5'h10), 32'h1);
    #2 reset_n = 1'b0;
    #1 check_all_zero("mid_reset");
    in_psel = 1'b0; in_penable = 1'b0;
    exp_acc.delete(); poll_left = 0;
    repeat (2) @(posedge clock);
    #3 reset_n = 1'b1;
    do_xfer(32'h3000_0008, 1'b0, 1, 32'h0102_0304);

    do_xfer(32'h30FF_FFFC, 1'b0, 1, 32'hCAFE_F00D);
    do_xfer(32'h3000_0000, 1'b0, 0, 32'h1357_9BDF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
